// File: rtl/alsu_sched_pkg.sv
// Shared types for the ALSU scheduler: opcodes, command bundle, flag positions
// and the lock FSM state encoding.
package alsu_sched_pkg;

  typedef enum logic [2:0] {
    AND       = 3'd0,
    XOR       = 3'd1,
    ADD       = 3'd2,
    MULT      = 3'd3,
    SHIFT     = 3'd4,
    ROTATE    = 3'd5,
    INVALID_6 = 3'd6,
    INVALID_7 = 3'd7
  } opcode_e;

  localparam int FLAG_RED_OP_A  = 0;
  localparam int FLAG_RED_OP_B  = 1;
  localparam int FLAG_BYPASS_A  = 2;
  localparam int FLAG_BYPASS_B  = 3;
  localparam int FLAG_DIRECTION = 4;
  localparam int FLAG_SERIAL_IN = 5;
  localparam int FLAG_CIN       = 6;
  localparam int NUM_FLAGS      = 7;

  typedef struct packed {
    opcode_e                opcode;
    logic [2:0]             a;
    logic [2:0]             b;
    logic [NUM_FLAGS-1:0]   flags;
  } alsu_cmd_t;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

endpackage

// File: rtl/alsu_rsp_fifo.sv
// First-word-fall-through response FIFO; the head is visible whenever not empty.
module alsu_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/alsu_sched.sv
// Round-robin scheduler sharing one ALSU between two requesters, with grant
// locking, latency tracking and a credit-protected response FIFO.
module alsu_sched
  import alsu_sched_pkg::*;
#(
  parameter int ALSU_LAT  = 2,
  parameter int RSP_DEPTH = 4,
  parameter int LOCK_MAX  = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_lock,
  input  logic [5:0]  req_opcode,
  input  logic [5:0]  req_a,
  input  logic [5:0]  req_b,
  input  logic [13:0] req_flags,
  output logic [2:0]  alsu_opcode,
  output logic [2:0]  alsu_a,
  output logic [2:0]  alsu_b,
  output logic [6:0]  alsu_flags,
  input  logic [5:0]  alsu_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [5:0]  rsp_data,
  output logic        busy,
  output logic        lock_err
);

  localparam int STAGES = ALSU_LAT + 1;
  localparam int SW     = $clog2(STAGES + 1);
  localparam int CW     = $clog2(RSP_DEPTH) + 1;
  localparam int IW     = $clog2(LOCK_MAX + 1);
  localparam logic [IW-1:0] LOCK_LAST = IW'(LOCK_MAX - 1);

  lock_state_e     state, state_next;
  logic            owner, owner_next;
  logic            rr_ptr, rr_next;
  logic [IW-1:0]   idle_cnt, idle_next;
  logic            err_set;
  logic            grant, gid;
  logic            credit_ok;
  alsu_cmd_t       cmd_sel, cmd_q;
  logic [STAGES-1:0] tag_v, tag_id;
  logic [SW-1:0]   inflight;
  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  logic [6:0]      fifo_head;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < STAGES; i++) inflight = inflight + SW'(tag_v[i]);
  end

  assign credit_ok = (int'(inflight) + int'(fifo_count)) < RSP_DEPTH;

  // Locked owner is the only candidate; otherwise the last loser wins ties.
  always_comb begin
    grant = 1'b0;
    gid   = 1'b0;
    if (rst_n && credit_ok) begin
      if (state == LOCKED) begin
        grant = req_valid[owner];
        gid   = owner;
      end else if (&req_valid) begin
        grant = 1'b1;
        gid   = rr_ptr;
      end else if (req_valid[0]) begin
        grant = 1'b1;
        gid   = 1'b0;
      end else if (req_valid[1]) begin
        grant = 1'b1;
        gid   = 1'b1;
      end
    end
  end

  assign req_ready = grant ? (gid ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    cmd_sel.opcode = opcode_e'(gid ? req_opcode[5:3] : req_opcode[2:0]);
    cmd_sel.a      = gid ? req_a[5:3] : req_a[2:0];
    cmd_sel.b      = gid ? req_b[5:3] : req_b[2:0];
    cmd_sel.flags  = gid ? req_flags[13:7] : req_flags[6:0];
  end

  always_comb begin
    state_next = state;
    owner_next = owner;
    idle_next  = idle_cnt;
    rr_next    = grant ? ~gid : rr_ptr;
    err_set    = 1'b0;
    case (state)
      UNLOCKED: begin
        if (grant && req_lock[gid]) begin
          state_next = LOCKED;
          owner_next = gid;
          idle_next  = '0;
        end
      end
      LOCKED: begin
        if (grant) begin
          idle_next = '0;
          if (!req_lock[gid]) state_next = UNLOCKED;
        end else if (!req_valid[owner]) begin
          if (idle_cnt == LOCK_LAST) begin
            state_next = UNLOCKED;
            idle_next  = '0;
            err_set    = 1'b1;
            rr_next    = ~owner;
          end else begin
            idle_next = idle_cnt + 1'b1;
          end
        end
      end
      default: state_next = UNLOCKED;
    endcase
  end

  // Idle cycles load a zero bubble so the ALSU never repeats a stale command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= UNLOCKED;
      owner    <= 1'b0;
      rr_ptr   <= 1'b0;
      idle_cnt <= '0;
      lock_err <= 1'b0;
      cmd_q    <= '0;
      tag_v    <= '0;
      tag_id   <= '0;
    end else begin
      state    <= state_next;
      owner    <= owner_next;
      rr_ptr   <= rr_next;
      idle_cnt <= idle_next;
      lock_err <= lock_err | err_set;
      cmd_q    <= grant ? cmd_sel : '0;
      tag_v    <= {tag_v[STAGES-2:0], grant};
      tag_id   <= {tag_id[STAGES-2:0], gid};
    end
  end

  assign alsu_opcode = cmd_q.opcode;
  assign alsu_a      = cmd_q.a;
  assign alsu_b      = cmd_q.b;
  assign alsu_flags  = cmd_q.flags;

  alsu_rsp_fifo #(.DEPTH(RSP_DEPTH), .WIDTH(7)) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tag_v[STAGES-1]),
    .push_data ({tag_id[STAGES-1], alsu_out}),
    .pop       (rsp_valid && rsp_ready),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rsp_valid          = !fifo_empty;
  assign {rsp_id, rsp_data} = fifo_empty ? 7'd0 : fifo_head;
  assign busy               = (inflight != '0) || !fifo_empty;

endmodule

// File: tb/tb_alsu_sched.sv
// Directed bench for alsu_sched with a two-cycle behavioural ALSU stand-in.
module tb_alsu_sched;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_lock;
  logic [5:0]  req_opcode;
  logic [5:0]  req_a;
  logic [5:0]  req_b;
  logic [13:0] req_flags;
  logic [2:0]  alsu_opcode;
  logic [2:0]  alsu_a;
  logic [2:0]  alsu_b;
  logic [6:0]  alsu_flags;
  logic [5:0]  alsu_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [5:0]  rsp_data;
  logic        busy;
  logic        lock_err;

  int pass_cnt = 0;
  int total_cnt = 0;

  alsu_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_lock   (req_lock),
    .req_opcode (req_opcode),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_flags  (req_flags),
    .alsu_opcode(alsu_opcode),
    .alsu_a     (alsu_a),
    .alsu_b     (alsu_b),
    .alsu_flags (alsu_flags),
    .alsu_out   (alsu_out),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .busy       (busy),
    .lock_err   (lock_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-edge ALSU stand-in; shift/rotate/invalid codes just return {b, a}.
  function automatic logic [5:0] alsu_model(input logic [2:0] op, input logic [2:0] a,
                                            input logic [2:0] b, input logic [6:0] fl);
    case (op)
      3'd0:    return {3'b0, a & b};
      3'd1:    return {3'b0, a ^ b};
      3'd2:    return {3'b0, a} + {3'b0, b} + {5'b0, fl[6]};
      3'd3:    return {3'b0, a} * {3'b0, b};
      default: return {b, a};
    endcase
  endfunction

  logic [5:0] alsu_p1 = 6'd0;
  initial alsu_out = 6'd0;
  always @(posedge clk) begin
    alsu_p1  <= alsu_model(alsu_opcode, alsu_a, alsu_b, alsu_flags);
    alsu_out <= alsu_p1;
  end

  typedef struct {
    logic       id;
    logic [2:0] op;
    logic [2:0] a;
    logic [2:0] b;
    logic [6:0] flags;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int r, input logic v, input logic [2:0] op,
                               input logic [2:0] a, input logic [2:0] b,
                               input logic [6:0] fl, input logic lk);
    req_valid[r]        = v;
    req_lock[r]         = lk;
    req_opcode[3*r +: 3] = op;
    req_a[3*r +: 3]      = a;
    req_b[3*r +: 3]      = b;
    req_flags[7*r +: 7]  = fl;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    else
      pass_cnt++;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int grants[$];
    int rsp_ids[$];
    int rsp_vals[$];
    int accepts;
    bit ok;

    vecs[0] = '{1'b0, 3'd2, 3'd3, 3'd2, 7'h00, 6'd5};
    vecs[1] = '{1'b0, 3'd0, 3'd3, 3'd5, 7'h00, 6'd1};
    vecs[2] = '{1'b1, 3'd1, 3'd6, 3'd3, 7'h00, 6'd5};
    vecs[3] = '{1'b0, 3'd3, 3'd7, 3'd7, 7'h00, 6'd49};
    vecs[4] = '{1'b1, 3'd2, 3'd7, 3'd7, 7'h40, 6'd15};
    vecs[5] = '{1'b0, 3'd4, 3'd3, 3'd6, 7'h10, 6'd51};
    vecs[6] = '{1'b1, 3'd6, 3'd1, 3'd2, 7'h00, 6'd17};
    vecs[7] = '{1'b1, 3'd7, 3'd5, 3'd4, 7'h00, 6'd37};

    rst_n = 1'b0;
    req_valid = '0; req_lock = '0; req_opcode = '0;
    req_a = '0; req_b = '0; req_flags = '0; rsp_ready = 1'b0;
    tick();
    tick();
    checkOutput("rst_req_ready", req_ready, 0);
    checkOutput("rst_alsu", {alsu_opcode, alsu_a, alsu_b, alsu_flags}, 0);
    checkOutput("rst_rsp", {rsp_valid, rsp_id, rsp_data}, 0);
    checkOutput("rst_busy_err", {busy, lock_err}, 0);

    // Reset one cycle after an accept must drop the result entirely.
    rst_n = 1'b1;
    tick();
    applyStimulus(0, 1'b1, 3'd0, 3'd3, 3'd5, 7'h00, 1'b0);
    #1;
    checkOutput("midrst_ready", req_ready, 2'b01);
    tick();
    req_valid = '0;
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_outputs", {alsu_opcode, alsu_a, alsu_b, alsu_flags, rsp_valid, busy}, 0);
    tick();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    ok = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (rsp_valid || busy) ok = 1'b0;
      tick();
    end
    checkOutput("midrst_no_rsp", ok, 1);
    rsp_ready = 1'b0;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(int'(vecs[i].id), 1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].flags, 1'b0);
      #1;
      checkOutput($sformatf("vec%0d_ready", i), req_ready, vecs[i].id ? 2'b10 : 2'b01);
      tick();
      req_valid = '0;
      checkOutput($sformatf("vec%0d_alsu", i), {alsu_opcode, alsu_a, alsu_b, alsu_flags},
                  {vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].flags});
      checkOutput($sformatf("vec%0d_busy", i), busy, 1);
      tick();
      checkOutput($sformatf("vec%0d_bubble", i), {alsu_opcode, alsu_a, alsu_b}, 0);
      tick();
      checkOutput($sformatf("vec%0d_early", i), rsp_valid, 0);
      tick();
      checkOutput($sformatf("vec%0d_valid", i), rsp_valid, 1);
      checkOutput($sformatf("vec%0d_id", i), rsp_id, vecs[i].id);
      checkOutput($sformatf("vec%0d_data", i), rsp_data, vecs[i].exp);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checkOutput($sformatf("vec%0d_popped", i), {rsp_valid, busy}, 0);
    end

    // Round robin: last table entry was requester 1, so requester 0 leads.
    applyStimulus(0, 1'b1, 3'd2, 3'd1, 3'd1, 7'h00, 1'b0);
    applyStimulus(1, 1'b1, 3'd1, 3'd2, 3'd3, 7'h00, 1'b0);
    rsp_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (req_ready != 2'b00) grants.push_back(int'(req_ready[1]));
      if (rsp_valid) begin
        rsp_ids.push_back(int'(rsp_id));
        rsp_vals.push_back(int'(rsp_data));
      end
      if (c == 29) req_valid = '0;
      tick();
    end
    checkOutput("rr_grant_count", grants.size() >= 6, 1);
    checkOutput("rr_rsp_count", rsp_ids.size() == grants.size(), 1);
    ok = 1'b1;
    for (int i = 0; i < 6 && i < grants.size(); i++)
      if (grants[i] != i % 2) ok = 1'b0;
    checkOutput("rr_alternate", ok, 1);
    ok = 1'b1;
    for (int i = 0; i < rsp_ids.size() && i < grants.size(); i++) begin
      if (rsp_ids[i] != grants[i]) ok = 1'b0;
      if (rsp_vals[i] != (grants[i] == 0 ? 2 : 1)) ok = 1'b0;
    end
    checkOutput("rr_rsp_order", ok, 1);
    checkOutput("rr_drained", busy, 0);

    // Backpressure: exactly RSP_DEPTH accepts, then one per freed entry.
    rsp_ready = 1'b0;
    req_valid = 2'b11;
    accepts = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (req_ready != 2'b00) accepts++;
      tick();
    end
    checkOutput("bp_accepts", accepts, 4);
    checkOutput("bp_stalled", {req_ready, rsp_valid}, 3'b001);
    rsp_ready = 1'b1;
    #1;
    checkOutput("bp_full_no_grant", req_ready, 0);
    tick();
    rsp_ready = 1'b0;
    accepts = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (req_ready != 2'b00) accepts++;
      tick();
    end
    checkOutput("bp_one_more", accepts, 1);
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 30 && busy; c++) tick();
    checkOutput("bp_drained", busy, 0);

    // Locked shift sequence holds off requester 1 until the unlock accept.
    applyStimulus(0, 1'b1, 3'd4, 3'd1, 3'd0, 7'h00, 1'b1);
    #1;
    checkOutput("lock_g1", req_ready, 2'b01);
    tick();
    checkOutput("lock_op1", alsu_opcode, 4);
    applyStimulus(1, 1'b1, 3'd1, 3'd2, 3'd2, 7'h00, 1'b0);
    #1;
    checkOutput("lock_g2", req_ready, 2'b01);
    tick();
    checkOutput("lock_op2", alsu_opcode, 4);
    req_lock[0] = 1'b0;
    #1;
    checkOutput("lock_g3", req_ready, 2'b01);
    tick();
    checkOutput("lock_op3", alsu_opcode, 4);
    req_valid[0] = 1'b0;
    #1;
    checkOutput("lock_g4", req_ready, 2'b10);
    tick();
    checkOutput("lock_op4", alsu_opcode, 1);
    req_valid = '0;
    for (int c = 0; c < 30 && busy; c++) tick();
    checkOutput("lock_drained", {busy, lock_err}, 0);

    // Lock timeout: owner goes idle; requester 1 waits out the idle limit.
    applyStimulus(0, 1'b1, 3'd5, 3'd2, 3'd0, 7'h00, 1'b1);
    #1;
    checkOutput("to_g0", req_ready, 2'b01);
    tick();
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b1;
    ok = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      #1;
      if (req_ready != 2'b00 || lock_err) ok = 1'b0;
      tick();
    end
    checkOutput("to_hold", ok, 1);
    checkOutput("to_err", lock_err, 1);
    checkOutput("to_grant1", req_ready, 2'b10);
    tick();
    req_valid = '0;
    for (int c = 0; c < 30 && busy; c++) tick();
    checkOutput("to_sticky", {busy, lock_err}, 2'b01);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
